// File: rtl/wb_pkg.sv
// Shared constants and state type for the writeback stage.
package wb_pkg;

  localparam int OPC_BITS = 4;

  localparam logic [OPC_BITS-1:0] STORE = 4'b1100;
  localparam logic [OPC_BITS-1:0] LOADA = 4'b1111;
  localparam logic [OPC_BITS-1:0] LOADB = 4'b1101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_decode.sv
// Opcode classifier: flags stores (no write) and loads (write memory data).
// Anything else is an ALU op that writes the ALU result.
module wb_decode
  import wb_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] i_opc,
  output logic             o_is_store,
  output logic             o_is_load
);

  // Pure compare against the shared opcode constants.
  always_comb begin
    o_is_store = (i_opc == OPC_W'(STORE));
    o_is_load  = (i_opc == OPC_W'(LOADA)) || (i_opc == OPC_W'(LOADB));
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: accepts one op per cycle, waits for load data when
// needed, and drives a one-cycle registered register-file write.
// Optional forwarding port enabled by macro WRITEBACK_STAGE_FWD_EN;
// without it the fwd_* outputs are tied to 0.
//
// state    | meaning
// IDLE     | nothing pending, ready for a new op
// WAIT_MEM | load accepted, waiting for mem_rvalid (not ready)
// COMMIT   | wb_en high this cycle, ready for a new op
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              err,
  output logic [15:0]       retired,
  output logic              fwd_pend,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  wb_state_t         r_state;
  logic              r_wb_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [15:0]       r_retired;

  logic w_is_store;
  logic w_is_load;
  logic w_accept;
  logic w_unused;

  // Only the opcode field of the instruction matters here.
  assign w_unused = ^in_instr[DATA_W-OPC_W-1:0];

  wb_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opc      (in_instr[DATA_W-1 -: OPC_W]),
    .o_is_store (w_is_store),
    .o_is_load  (w_is_load)
  );

  assign in_ready = (r_state != WAIT_MEM);
  assign busy     = (r_state != IDLE);
  assign w_accept = in_valid && in_ready;

  assign wb_en   = r_wb_en;
  assign wb_addr = r_addr;
  assign wb_data = r_data;
  assign err     = r_err;
  assign retired = r_retired;

  // Sequencer: state, registered write port, sticky error and retire count.
  // retired counts a write on entry to COMMIT so it is already updated
  // while wb_en is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_wb_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_wb_en <= 1'b0;
      if (mem_rvalid && (r_state != WAIT_MEM)) r_err <= 1'b1;
      case (r_state)
        IDLE, COMMIT: begin
          if (w_accept) begin
            r_addr <= in_addr;
            if (w_is_store) begin
              r_state   <= IDLE;
              r_retired <= r_retired + 16'd1;
            end else if (w_is_load) begin
              r_state <= WAIT_MEM;
            end else begin
              r_state   <= COMMIT;
              r_data    <= in_alu;
              r_wb_en   <= 1'b1;
              r_retired <= r_retired + 16'd1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            r_state   <= COMMIT;
            r_data    <= mem_rdata;
            r_wb_en   <= 1'b1;
            r_retired <= r_retired + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WRITEBACK_STAGE_FWD_EN
  // Forwarding: pending destination while waiting, write data while committing.
  always_comb begin
    fwd_pend  = (r_state == WAIT_MEM);
    fwd_addr  = fwd_pend ? r_addr : '0;
    fwd_valid = r_wb_en;
    fwd_data  = r_wb_en ? r_data : '0;
  end
`else
  // Forwarding disabled: ports kept, driven low.
  always_comb begin
    fwd_pend  = 1'b0;
    fwd_addr  = '0;
    fwd_valid = 1'b0;
    fwd_data  = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage with a
// transaction-level reference model.
module tb_writeback_stage;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_instr;
  logic [19:0] in_alu;
  logic [3:0]  in_addr;
  logic        mem_rvalid;
  logic [19:0] mem_rdata;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [19:0] wb_data;
  logic        busy;
  logic        err;
  logic [15:0] retired;
  logic        fwd_pend;
  logic [3:0]  fwd_addr;
  logic        fwd_valid;
  logic [19:0] fwd_data;

  writeback_stage #(.DATA_W(20), .ADDR_W(4), .OPC_W(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_alu     (in_alu),
    .in_addr    (in_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .err        (err),
    .retired    (retired),
    .fwd_pend   (fwd_pend),
    .fwd_addr   (fwd_addr),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a load in flight, a write due now, counters.
  bit          m_wait;
  bit          m_wb;
  logic [3:0]  m_load_addr;
  logic [3:0]  m_wb_addr;
  logic [19:0] m_wb_data;
  logic [15:0] m_ret;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wb = 0; m_load_addr = '0; m_wb_addr = '0; m_wb_data = '0;
    m_ret = '0; m_err = 0;
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(!m_wait));
    chk("busy",     32'(busy),     32'(m_wait || m_wb));
    chk("wb_en",    32'(wb_en),    32'(m_wb));
    if (m_wb) begin
      chk("wb_addr", 32'(wb_addr), 32'(m_wb_addr));
      chk("wb_data", 32'(wb_data), 32'(m_wb_data));
    end
    chk("retired", 32'(retired), 32'(m_ret));
    chk("err",     32'(err),     32'(m_err));
`ifdef WRITEBACK_STAGE_FWD_EN
    chk("fwd_pend",  32'(fwd_pend),  32'(m_wait));
    chk("fwd_addr",  32'(fwd_addr),  m_wait ? 32'(m_load_addr) : 32'd0);
    chk("fwd_valid", 32'(fwd_valid), 32'(m_wb));
    chk("fwd_data",  32'(fwd_data),  m_wb ? 32'(m_wb_data) : 32'd0);
`else
    chk("fwd_pend",  32'(fwd_pend),  32'd0);
    chk("fwd_addr",  32'(fwd_addr),  32'd0);
    chk("fwd_valid", 32'(fwd_valid), 32'd0);
    chk("fwd_data",  32'(fwd_data),  32'd0);
`endif
  endtask

  // One clock: check what the DUT shows now, present new inputs, and let
  // the model predict what the next cycle should show.
  task automatic cyc(input bit v, input logic [19:0] instr, input logic [19:0] alu,
                     input logic [3:0] addr, input bit rv, input logic [19:0] rd);
    logic [3:0] opc;
    bit acc;
    @(negedge clock);
    check_all();
    in_valid = v; in_instr = instr; in_alu = alu; in_addr = addr;
    mem_rvalid = rv; mem_rdata = rd;
    opc = instr[19:16];
    acc = v && !m_wait;
    if (rv && !m_wait) m_err = 1;
    if (m_wait) begin
      m_wb = rv;
      if (rv) begin
        m_wait = 0;
        m_wb_addr = m_load_addr;
        m_wb_data = rd;
        m_ret = m_ret + 16'd1;
      end
    end else begin
      m_wb = 0;
      if (acc) begin
        if (opc == 4'b1100) begin
          m_ret = m_ret + 16'd1;
        end else if (opc == 4'b1111 || opc == 4'b1101) begin
          m_wait = 1;
          m_load_addr = addr;
        end else begin
          m_wb = 1;
          m_wb_addr = addr;
          m_wb_data = alu;
          m_ret = m_ret + 16'd1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 0;
    in_valid = 0; in_instr = '0; in_alu = '0; in_addr = '0;
    mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    @(negedge clock);
    chk("rst_wb_en",   32'(wb_en),   32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_fwd",     32'({fwd_pend, fwd_addr, fwd_valid}), 32'd0);
    chk("rst_fwd_data", 32'(fwd_data), 32'd0);
    resetn = 1;
  endtask

  initial begin
    logic [3:0]  opc;
    logic [19:0] instr;
    resetn = 0;
    in_valid = 0; in_instr = '0; in_alu = '0; in_addr = '0;
    mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    do_reset();

    // Single ALU op: write one cycle later, retired=1.
    cyc(1, 20'h3ABCD, 20'h12345, 4'd5, 0, '0);
    cyc(0, '0, '0, '0, 0, '0);
    chk("alu_retired", 32'(retired), 32'd1);
    idle(1);

    // Load, response three cycles after accept.
    cyc(1, 20'hF0000, 20'h11111, 4'd9, 0, '0);
    cyc(1, 20'h00000, 20'h22222, 4'd3, 0, '0);
    idle(1);
    cyc(0, '0, '0, '0, 1, 20'hBEEF0);
    cyc(0, '0, '0, '0, 0, '0);
    chk("load_data", 32'(wb_data), 32'hBEEF0);
    idle(1);

    // Store: no write, retired +1.
    cyc(1, 20'hC1234, 20'h55555, 4'd7, 0, '0);
    idle(2);

    // Four back-to-back ALU ops.
    for (int i = 1; i <= 4; i++) cyc(1, 20'h20000, 20'(i * 16'h111), 4'(i), 0, '0);
    idle(2);

    // Reset during WAIT_MEM, rvalid after release.
    cyc(1, 20'hD0000, '0, 4'd6, 0, '0);
    idle(1);
    do_reset();
    cyc(0, '0, '0, '0, 1, 20'hABCDE);
    idle(2);
    chk("rst_drop_err", 32'(err), 32'd1);
    chk("rst_drop_ret", 32'(retired), 32'd0);

    // Wrap of the retire counter.
    do_reset();
    for (int i = 0; i < 65535; i++) cyc(1, 20'hC0000, '0, 4'(i), 0, '0);
    cyc(1, 20'h40000, 20'h0F0F0, 4'd2, 0, '0);
    cyc(0, '0, '0, '0, 0, '0);
    chk("wrap_retired", 32'(retired), 32'd0);
    idle(1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: opc = 4'b1100;
        1: opc = 4'b1111;
        2: opc = 4'b1101;
        default: opc = 4'($urandom);
      endcase
      instr = {opc, 16'($urandom)};
      cyc($urandom_range(0, 99) < 60, instr, 20'($urandom), 4'($urandom),
          $urandom_range(0, 99) < 30, 20'($urandom));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 20, meaning the instruction/data word width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the register address width.
REQ-003 SHALL have parameter OPC_W, default 4, meaning the opcode width, taken from in_instr[DATA_W-1 -: OPC_W].
REQ-004 SHALL have port clock, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn, input, 1 bit, with asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, DATA_W), in_alu (input, DATA_W) and in_addr (input, ADDR_W), forming the upstream handshake and payload.
REQ-007 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, DATA_W), carrying the load response from the memory stage.
REQ-008 SHALL have ports wb_en (output, 1), wb_addr (output, ADDR_W) and wb_data (output, DATA_W), forming the registered register-file write port.
REQ-009 SHALL have ports busy (output, 1), err (output, 1, sticky) and retired (output, 16, retire counter).
REQ-010 SHALL have ports fwd_pend (output, 1), fwd_addr (output, ADDR_W), fwd_valid (output, 1) and fwd_data (output, DATA_W), forming the hazard/forwarding port (see Configuration).

Function
REQ-011 SHALL decode opcodes as follows: STORE=1100 means no write; LOADA=1111 and LOADB=1101 mean write mem_rdata; every other opcode means write in_alu.
REQ-012 SHALL implement states IDLE, WAIT_MEM and COMMIT; in_ready SHALL be 1 in IDLE or COMMIT and 0 in WAIT_MEM.
REQ-013 SHALL define accept as in_valid && in_ready, and on accept SHALL latch in_addr.
REQ-014 SHALL, on accept of an ALU op, latch in_alu and go to COMMIT, asserting wb_en in the next cycle (latency 1).
REQ-015 SHALL, on accept of a load, go to WAIT_MEM; in WAIT_MEM with mem_rvalid=1 it SHALL latch mem_rdata and go to COMMIT, asserting wb_en in the cycle after mem_rvalid.
REQ-016 SHALL, on accept of a store, go to (or stay in) IDLE, leave wb_en=0, and increment retired.
REQ-017 SHALL hold wb_en=1 for exactly one cycle per COMMIT state, with wb_addr/wb_data stable during that cycle.
REQ-018 SHALL, in COMMIT with a simultaneous accept, take the next state from the new op (back-to-back ALU ops give a 1-per-cycle throughput), and without an accept SHALL go to IDLE.
REQ-019 SHALL ignore mem_rvalid outside WAIT_MEM, except that it SHALL set err=1, which stays set until reset.
REQ-020 SHALL remain in WAIT_MEM indefinitely without mem_rvalid, with busy=1.
REQ-021 SHALL increment retired (16-bit, wrapping from FFFF to 0000) once per wb_en pulse and once per accepted store.
REQ-022 SHALL drive busy=1 whenever the state is not IDLE.

Reset
REQ-023 SHALL, while resetn=0, force the state to IDLE and drive wb_en=0, wb_addr=0, wb_data=0, err=0, retired=0, busy=0 and all fwd_* outputs to 0.
REQ-024 SHALL, on reset asserted in WAIT_MEM or COMMIT, drop the pending write, so that no wb_en occurs after reset release.

Configuration
REQ-025 SHALL, with macro WRITEBACK_STAGE_FWD_EN defined, drive fwd_pend=1 with fwd_addr equal to the latched address in WAIT_MEM, and drive fwd_valid=1 with fwd_data equal to wb_data in COMMIT.
REQ-026 SHALL, without WRITEBACK_STAGE_FWD_EN, keep the fwd_* ports present but tie them to 0; all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place the opcode constants (STORE, LOADA, LOADB) and the state enumeration in shared package wb_pkg.
REQ-028 SHALL contain one combinational sub-module, wb_decode, which maps an opcode to is_store and is_load.

Verification
REQ-029 SHALL cover: reset, then ALU op instr=0x3ABCD, alu=0x12345, addr=5 -> next cycle wb_en=1, wb_addr=5, wb_data=0x12345, retired=1.
REQ-030 SHALL cover: load opcode 1111, addr=9; mem_rvalid asserted 3 cycles later with rdata=0xBEEF0 -> in_ready=0 and busy=1 while waiting, then wb_en=1 with wb_data=0xBEEF0 one cycle after rvalid; with FWD_EN, fwd_pend=1 and fwd_addr=9 while waiting.
REQ-031 SHALL cover: store opcode 1100 accepted -> wb_en stays 0 and retired increments by 1.
REQ-032 SHALL cover: four back-to-back ALU ops with addr 1..4 -> wb_en high for 4 consecutive cycles with matching addresses, and in_ready stays 1.
REQ-033 SHALL cover: resetn pulsed low during WAIT_MEM, then mem_rvalid after release -> no wb_en, err=1, retired=0.
REQ-034 SHALL cover: retired preloaded to 0xFFFF via 65535 stores, then one ALU op -> retired=0x0000.
